// File: rtl/counter_button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding and the sizing rule for the per-channel timing counter.
package counter_button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    REL_CHK   = 3'd4
  } btn_state_e;

  // Counter must hold the largest terminal count of any timing phase.
  function automatic int cnt_width(input int debounce_cycles,
                                   input int repeat_delay,
                                   input int repeat_period);
    int max_val;
    max_val = debounce_cycles;
    if (repeat_delay > max_val) max_val = repeat_delay;
    if (repeat_period > max_val) max_val = repeat_period;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/counter_button_conditioner_channel.sv
// One conditioner channel: 2-FF synchroniser, debounce/repeat FSM with a
// shared saturating counter, and registered level/press/release/repeat outputs.
module counter_button_conditioner_channel
  import counter_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_LAST   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST   = CW'(REPEAT_PERIOD - 1);
  localparam bit            REPEAT_EN = (REPEAT_PERIOD != 0);

  logic          sync_meta_reg;
  logic          sync_reg;
  btn_state_e    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_inc;
  logic          level_reg;
  logic          press_reg;
  logic          release_reg;
  logic          repeat_reg;

  // Counter never wraps: it sticks at all-ones once reached.
  assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_ONE;

  // Synchroniser runs independently of ena so the FSM sees fresh data on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= btn_raw;
      sync_reg      <= sync_meta_reg;
    end
  end

  // Debounce / auto-repeat FSM; strobes default low and ena=0 freezes everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      if (ena) begin
        case (state_reg)
          IDLE: begin
            if (sync_reg) begin
              state_reg <= PRESS_CHK;
              cnt_reg   <= CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!sync_reg) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
              level_reg <= 1'b1;
              press_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          HELD: begin
            if (!sync_reg) begin
              state_reg <= REL_CHK;
              cnt_reg   <= CNT_ONE;
            end else if (REPEAT_EN && (cnt_reg == RD_LAST)) begin
              state_reg  <= REPEAT;
              cnt_reg    <= '0;
              repeat_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          REPEAT: begin
            if (!sync_reg) begin
              state_reg <= REL_CHK;
              cnt_reg   <= CNT_ONE;
            end else if (cnt_reg == RP_LAST) begin
              cnt_reg    <= '0;
              repeat_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          REL_CHK: begin
            // A bounce back high restarts the repeat timer from the press point.
            if (sync_reg) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_reg   <= IDLE;
              cnt_reg     <= '0;
              level_reg   <= 1'b0;
              release_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = release_reg;
  assign btn_repeat  = repeat_reg;

endmodule

// File: rtl/counter_button_conditioner.sv
// Button conditioner top: N_CH independent conditioner channels sharing
// clock, reset and the design-select enable.
module counter_button_conditioner #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      counter_button_conditioner_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn_raw     (btn_in[gi]),
        .btn_level   (btn_level[gi]),
        .btn_press   (btn_press[gi]),
        .btn_release (btn_release[gi]),
        .btn_repeat  (btn_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter_button_conditioner.sv
// Scoreboard bench for counter_button_conditioner: a run-length reference
// model pushes the expected output vector each clock, a monitor pops and
// compares on the falling edge. A second instance built without repeat
// shares the stimulus.
module tb_counter_button_conditioner;

  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [3:0] btn_in = 4'h0;

  logic [3:0] lvl_a, prs_a, rel_a, rpt_a;
  logic [3:0] lvl_b, prs_b, rel_b, rpt_b;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  counter_button_conditioner #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn_in),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rpt_a)
  );

  counter_button_conditioner #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(0)
  ) dut_norpt (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn_in),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rpt_b)
  );

  task automatic check(input string name, input exp_t act, input exp_t want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got lvl=%b press=%b rel=%b rpt=%b, expected lvl=%b press=%b rel=%b rpt=%b",
               name, $time, act.lvl, act.prs, act.rel, act.rpt,
               want.lvl, want.prs, want.rel, want.rpt);
    end else if ((want.prs | want.rel | want.rpt) != 4'h0) begin
      $display("%s @%0t: lvl=%b press=%b rel=%b rpt=%b",
               name, $time, act.lvl, act.prs, act.rel, act.rpt);
    end
  endtask

  // Reference model: a change is accepted after DEB+1 consecutive enabled
  // cycles of the synchronised input disagreeing with the level; repeats
  // fall at RD, RD+RP, ... enabled held cycles after press (or after a
  // release bounce).
  initial begin : model
    logic [3:0] m_lvl, d1, d2, sync_v;
    int   run  [4];
    int   held [4];
    exp_t e;
    m_lvl = '0; d1 = '0; d2 = '0;
    for (int c = 0; c < 4; c++) begin run[c] = 0; held[c] = 0; end
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_lvl = '0; d1 = '0; d2 = '0;
        for (int c = 0; c < 4; c++) begin run[c] = 0; held[c] = 0; end
      end else begin
        sync_v = d2;
        d2     = d1;
        d1     = btn_in;
        if (ena) begin
          for (int c = 0; c < 4; c++) begin
            if (sync_v[c] != m_lvl[c]) begin
              run[c]++;
              if (run[c] == DEB + 1) begin
                m_lvl[c] = ~m_lvl[c];
                if (m_lvl[c]) e.prs[c] = 1'b1;
                else          e.rel[c] = 1'b1;
                run[c]  = 0;
                held[c] = 0;
              end
            end else if (run[c] > 0) begin
              run[c]  = 0;
              held[c] = 0;
            end else if (m_lvl[c]) begin
              held[c]++;
              if (held[c] >= RD && ((held[c] - RD) % RP) == 0) e.rpt[c] = 1'b1;
            end
          end
        end
      end
      e.lvl = m_lvl;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected vector per clock, compared mid-cycle.
  initial begin : monitor
    exp_t e;
    exp_t e_nr;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e    = exp_q.pop_front();
        e_nr = e;
        e_nr.rpt = 4'h0;
        check("main", {lvl_a, prs_a, rel_a, rpt_a}, e);
        check("norpt", {lvl_b, prs_b, rel_b, rpt_b}, e_nr);
      end
    end
  end

  task automatic hold(input logic [3:0] v, input int n);
    btn_in = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_main", {lvl_a, prs_a, rel_a, rpt_a}, '0);
    check("async_rst_norpt", {lvl_b, prs_b, rel_b, rpt_b}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int cd[4];
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Reset while all channels are held, then re-press after release.
    hold(4'hF, 20);
    reset_pulse();
    hold(4'hF, 15);
    hold(4'h0, 12);

    // Clean press on channel 0.
    hold(4'b0001, 15);
    hold(4'b0000, 12);

    // Short glitch on channel 1, then a one-cycle dip while held.
    hold(4'b0010, 3);
    hold(4'b0000, 10);
    hold(4'b0010, 12);
    hold(4'b0000, 1);
    hold(4'b0010, 12);
    hold(4'b0000, 12);

    // Auto-repeat on channel 2.
    hold(4'b0100, 30);
    hold(4'b0000, 12);

    // ena dropped partway through a press on channel 3.
    hold(4'b1000, 4);
    ena = 1'b0;
    hold(4'b1000, 10);
    ena = 1'b1;
    hold(4'b1000, 20);
    hold(4'b0000, 12);

    // Simultaneous presses on two channels.
    hold(4'b1010, 20);
    hold(4'b0000, 12);

    // Long hold on every channel.
    hold(4'hF, 110);
    hold(4'h0, 12);

    // Randomised hold lengths (short ones act as bounces) with random ena drops.
    for (int c = 0; c < 4; c++) cd[c] = $urandom_range(1, 40);
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < 4; c++) begin
        cd[c]--;
        if (cd[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          cd[c] = $urandom_range(1, 40);
        end
      end
      ena = ($urandom_range(0, 15) != 0);
      if (i == 1200 || i == 2100) reset_pulse();
      @(posedge clk);
      #2;
    end
    ena = 1'b1;
    hold(4'h0, 15);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
